// File: rtl/compressor_pkg.sv
// Shared definitions for the multichannel compressor: ratio encodings,
// controller state enum and the saturating absolute-value helper.
package compressor_pkg;

  // ratio_sel encodings; the value is also the right-shift r used for the reduction
  localparam logic [1:0] RATIO_BYPASS = 2'd0;
  localparam logic [1:0] RATIO_2      = 2'd1;
  localparam logic [1:0] RATIO_4      = 2'd2;
  localparam logic [1:0] RATIO_8      = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StMag,
    StGain,
    StApply,
    StDone
  } state_e;

  // |x| clipped to 2^(width-1)-1 so the most-negative sample maps to full scale
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned width);
    logic signed [31:0] max_pos;
    logic signed [31:0] a;
    max_pos = (32'sd1 <<< (width - 1)) - 32'sd1;
    a = (x < 0) ? -x : x;
    if (a > max_pos) a = max_pos;
    return unsigned'(a);
  endfunction

endpackage

// File: rtl/compressor_multichannel_if.sv
// Frame handshake and control bundle between sample source and compressor.
// makeup_shift exists only when COMPRESSOR_MAKEUP_GAIN_EN is defined.
interface compressor_multichannel_if
  import compressor_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 2
);
  logic                      start;
  logic                      enable;
  logic [CHANNELS*WIDTH-1:0] sample_in;
  logic [WIDTH-2:0]          threshold;
  logic [1:0]                ratio_sel;
  logic [3:0]                attack_shift;
  logic [3:0]                release_shift;
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
  logic [1:0]                makeup_shift;
`endif
  logic [CHANNELS*WIDTH-1:0] sample_out;
  logic [WIDTH-2:0]          gain_reduction;
  logic                      busy;
  logic                      done;

  modport master (
    output start, enable, sample_in, threshold, ratio_sel, attack_shift, release_shift,
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
    output makeup_shift,
`endif
    input  sample_out, gain_reduction, busy, done
  );

  modport slave (
    input  start, enable, sample_in, threshold, ratio_sel, attack_shift, release_shift,
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
    input  makeup_shift,
`endif
    output sample_out, gain_reduction, busy, done
  );

endinterface

// File: rtl/compressor_envelope.sv
// Per-channel peak envelope follower: one shared update datapath plus an
// envelope register per channel, selected by the channel index.
module compressor_envelope
  import compressor_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             update,
  input  logic [ChW-1:0]   ch,
  input  logic [WIDTH-2:0] mag,
  input  logic [3:0]       attack_shift,
  input  logic [3:0]       release_shift,
  output logic [WIDTH-2:0] env
);

  logic [WIDTH-2:0] env_q [CHANNELS];
  logic [WIDTH-2:0] env_next;

  assign env = env_q[ch];

  // Move a shifted fraction of the gap toward mag; the step never overshoots, so no wrap
  always_comb begin
    env_next = env;
    if (mag > env) env_next = env + ((mag - env) >> attack_shift);
    else           env_next = env - ((env - mag) >> release_shift);
  end

  // Envelope storage, written only during the channel's magnitude step
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) env_q[i] <= '0;
    end else if (update) begin
      env_q[ch] <= env_next;
    end
  end

endmodule

// File: rtl/compressor_multichannel.sv
// Time-multiplexed hard-knee compressor: per channel MAG -> GAIN -> APPLY,
// then a one-cycle DONE that publishes the frame. Optional makeup gain is
// enabled with COMPRESSOR_MAKEUP_GAIN_EN.
module compressor_multichannel
  import compressor_pkg::*;
#(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned SAMPLING_RATE = 24000
) (
  input logic                       clock,
  input logic                       reset,
  compressor_multichannel_if.slave  bus
);

  localparam int unsigned    ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned    BoostW = WIDTH + 3;
  localparam logic [BoostW-1:0] MaxPos = BoostW'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0]  MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [ChW-1:0]    LastCh = ChW'(CHANNELS - 1);

  state_e                    state_q, state_d;
  logic [ChW-1:0]            ch_q, ch_d;

  logic [CHANNELS*WIDTH-1:0] frame_q, work_q, frame_next, sample_out_q;
  logic                      enable_q;
  logic [1:0]                ratio_q;
  logic [WIDTH-2:0]          threshold_q;
  logic [3:0]                attack_q, release_q;
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
  logic [1:0]                makeup_q;
`endif
  logic [WIDTH-2:0]          mag_q, red_q, red_max_q, red_max_next, gain_q;

  logic signed [WIDTH-1:0]   x_cur;
  logic [WIDTH-2:0]          mag_cur, env_cur, excess, red_cur, res_mag;
  logic [BoostW-1:0]         boosted;
  logic [WIDTH-1:0]          y;

  assign x_cur   = frame_q[ch_q*WIDTH +: WIDTH];
  assign mag_cur = (WIDTH - 1)'(sat_abs(32'(x_cur), WIDTH));

  compressor_envelope #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_envelope (
    .clock         (clock),
    .reset         (reset),
    .update        (state_q == StMag),
    .ch            (ch_q),
    .mag           (mag_cur),
    .attack_shift  (attack_q),
    .release_shift (release_q),
    .env           (env_cur)
  );

  // Controller state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Sequencing: three steps per channel, start honoured only when idle
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StMag;
          ch_d    = '0;
        end
      end
      StMag:  state_d = StGain;
      StGain: state_d = StApply;
      StApply: begin
        if (ch_q == LastCh) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StMag;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Subtractive reduction from the envelope excess over threshold
  always_comb begin
    excess  = (env_cur > threshold_q) ? env_cur - threshold_q : '0;
    red_cur = excess - (excess >> ratio_q);
    if (!enable_q || ratio_q == RATIO_BYPASS) red_cur = '0;
  end

  // Apply reduction, optional makeup boost, restore sign with saturation
  always_comb begin
    res_mag = (mag_q > red_q) ? mag_q - red_q : '0;
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
    boosted = BoostW'(res_mag) << makeup_q;
`else
    boosted = BoostW'(res_mag);
`endif
    // A zero magnitude negates to zero, so no negative zero can appear
    if (x_cur[WIDTH-1]) y = (boosted > MaxPos) ? MinNeg : -WIDTH'(boosted);
    else                y = (boosted > MaxPos) ? MaxPos[WIDTH-1:0] : WIDTH'(boosted);
    frame_next = work_q;
    frame_next[ch_q*WIDTH +: WIDTH] = y;
    red_max_next = (red_q > red_max_q) ? red_q : red_max_q;
  end

  // Datapath registers; the output frame is published on entry to DONE
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_q      <= '0;
      work_q       <= '0;
      sample_out_q <= '0;
      enable_q     <= 1'b0;
      ratio_q      <= '0;
      threshold_q  <= '0;
      attack_q     <= '0;
      release_q    <= '0;
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
      makeup_q     <= '0;
`endif
      mag_q        <= '0;
      red_q        <= '0;
      red_max_q    <= '0;
      gain_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            frame_q     <= bus.sample_in;
            enable_q    <= bus.enable;
            ratio_q     <= bus.ratio_sel;
            threshold_q <= bus.threshold;
            attack_q    <= bus.attack_shift;
            release_q   <= bus.release_shift;
`ifdef COMPRESSOR_MAKEUP_GAIN_EN
            makeup_q    <= bus.makeup_shift;
`endif
            red_max_q   <= '0;
          end
        end
        StMag:  mag_q <= mag_cur;
        StGain: red_q <= red_cur;
        StApply: begin
          work_q    <= frame_next;
          red_max_q <= red_max_next;
          if (ch_q == LastCh) begin
            sample_out_q <= frame_next;
            gain_q       <= red_max_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sample_out     = sample_out_q;
  assign bus.gain_reduction = gain_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = (state_q == StDone);

endmodule
